instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the producer side of the decode-stage instruction word. It generates sequential PCs, reads 32-bit words over a Wishbone-classic instruction port, and buffers them in a small FIFO. It presents {instruction, pc, exception} to the decoder with a valid/ready handshake. Control-flow redirects from execute flush the buffer and squash any in-flight read.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, FIFO entries (power of two, ≥2)
- `clk_i` in 1: single clock, all state on rising edge
- `rst_i` in 1: asynchronous, active-low reset
- `iport_addr_o` out 32: word address (bits [1:0] always 0)
- `iport_cyc_o` out 1: bus cycle active
- `iport_stb_o` out 1: strobe, equal to `iport_cyc_o`
- `iport_dat_i` in 32: read data, valid with ack
- `iport_ack_i` in 1: read completed; may be combinational in the same cycle as strobe
- `iport_err_i` in 1: bus error, terminates cycle like ack
- `redirect_i` in 1: flush and restart at `redirect_pc_i`
- `redirect_pc_i` in 32: new PC
- `instruction_o` out 32: head instruction word
- `pc_o` out 32: PC of head entry
- `e_fetch_misaligned_o` out 1: head entry is an instruction-misaligned exception
- `e_fetch_fault_o` out 1: head entry is an instruction-access fault
- `valid_o` out 1: head entry present
- `ready_i` in 1: decoder accepts head this cycle

## Operation
- States: IDLE, REQ, WAIT, DISCARD, HALT.
- **IDLE:** entered only from reset. Goes to REQ unconditionally on the next edge.
- **REQ:** `iport_cyc_o` and `iport_stb_o` are high, `iport_addr_o` = fetch_pc.
  - On ack: push {dat, fetch_pc, 0, 0}; fetch_pc += 4.
  - Stay in REQ if post-update count < DEPTH, else go to WAIT.
- **WAIT:** bus idle. Return to REQ once count < DEPTH, i.e. the cycle after a pop.
- **Bus error in REQ:** push {32'h0000_0013, fetch_pc, 0, 1}, then go to HALT.
- **HALT:** bus idle, no further fetches until a redirect.
- **Redirect:**
  - FIFO is cleared at the edge and fetch_pc <= redirect_pc_i.
  - If `redirect_pc_i[1:0]` ≠ 0: push {NOP, redirect_pc_i, 1, 0} and go to HALT; no bus access.
  - Else, if in REQ without ack/err that cycle: go to DISCARD.
  - Otherwise: go to REQ.
- **DISCARD:** cyc/stb stay high with the old address until ack/err. The response is dropped, then go to REQ at the new fetch_pc. A second redirect in DISCARD only updates fetch_pc.
- **Priority:**
  - `redirect_i` wins over push and pop.
  - A valid&ready handshake in a redirect cycle counts as accepted.
  - Push and pop in the same cycle leave count unchanged.
- **Wrap:** fetch_pc wraps modulo 2^32, from 32'hFFFF_FFFC to 0.
- **Outputs:**
  - `valid_o` = (count ≠ 0).
  - Head fields are driven from FIFO storage, not from bus data.
  - When empty, head fields read as NOP, PC 0, flags 0.
- **Reset mid-operation:** all state is cleared immediately. An outstanding bus cycle is abandoned; cyc drops asynchronously.

## Timing
- Reset values:
  - `iport_cyc_o` = `iport_stb_o` = 0
  - `iport_addr_o` = RESET_PC
  - `valid_o` = 0, `instruction_o` = 32'h0000_0013, `pc_o` = 0
  - both exception flags = 0
  - state IDLE, count 0
- First strobe one cycle after reset release.
- Ack-to-valid latency is 1 cycle.
- With zero-wait-state memory and ready_i held high: one instruction per cycle, strobe continuously high.
- Redirect:
  - `valid_o` low the cycle after a redirect edge.
  - Earliest new strobe is the same cycle the redirect is registered (state REQ), or after the squashed ack (DISCARD).
- At most one outstanding bus cycle.

## Structure
- Shared package holds:
  - state encoding
  - NOP constant 32'h0000_0013
  - exception cause codes: 0 = misaligned, 1 = access fault, reused by the trap unit
  - entry-width constant (32 + 32 + 2)
- One sub-module `fetch_fifo`:
  - synchronous DEPTH-entry FIFO with push, pop, clear, count, and head data
  - same asynchronous active-low reset

## Test plan
- **Reset and stream:** reset release, zero-wait ack, ready_i = 1 → addresses 0, 4, 8… on consecutive cycles; `pc_o`/`instruction_o` match memory one cycle later.
- **Backpressure:** DEPTH = 2, ready_i = 0 → two entries {0, 4} buffered, cyc drops (WAIT). Raising ready_i → fetch resumes at 8 the cycle after the first pop.
- **Squash:** redirect to 32'h100 while a read of 32'h40 is pending with 3-cycle latency → the 0x40 data is never presented; next strobe addr 0x100; first valid `pc_o` = 0x100.
- **Misaligned:** redirect_pc_i = 32'h102 → one entry with pc 0x102, `e_fetch_misaligned_o` = 1, no bus cycle, HALT until the next redirect.
- **Bus error:** err at 0x20 → entry {NOP, 0x20, fault = 1}, no strobe afterwards; redirect to 0x0 restarts fetch.
- **Simultaneous events:** redirect in the same cycle as ack, and as a pop with a full FIFO → data dropped, FIFO empty next cycle, fetch at the new PC, no duplicate entries.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// the NOP filler word, exception cause codes and the buffer entry layout.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DISCARD,
    ST_HALT
  } fetch_state_e;

  // addi x0, x0, 0 -- presented whenever there is no real instruction word
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Cause codes shared with the trap unit; also used as bit positions in
  // the per-entry exception field.
  localparam int CAUSE_FETCH_MISALIGNED = 0;
  localparam int CAUSE_FETCH_FAULT      = 1;

  // Entry = {instruction[31:0], pc[31:0], exc[1:0]}
  localparam int ENTRY_W = 32 + 32 + 2;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [31:0] instr,
                                                    input logic [31:0] pc,
                                                    input logic [1:0]  exc);
    return {instr, pc, exc};
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small power-of-two FIFO between the bus side and the decoder.
// Head data is visible combinationally from storage; clear discards all
// entries and may be combined with a push in the same cycle.
module fetch_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               wr_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;
  logic [AW-1:0] wr_idx;

  assign pop_ok  = pop && (count_reg != '0);
  assign push_ok = push && ((count_reg != (AW+1)'(DEPTH)) || pop_ok);
  // After a clear the surviving push lands in slot 0
  assign wr_idx  = clear ? '0 : wr_ptr_reg;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= AW'(push);
      count_reg  <= (AW+1)'(push);
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; contents only matter while counted as occupied
  always_ff @(posedge clk) begin
    if (push && (clear || push_ok)) mem[wr_idx] <= wr_data;
  end

  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC generation, Wishbone-classic
// instruction reads, and a small buffer feeding the decoder through a
// valid/ready handshake. Redirects flush the buffer and squash any read
// that is still outstanding.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_dat_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        e_fetch_misaligned_o,
  output logic        e_fetch_fault_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e       state_reg, state_next;
  logic [31:0]        fetch_pc_reg, fetch_pc_next;
  logic [31:0]        discard_addr_reg, discard_addr_next;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_clear;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CW-1:0]      fifo_count;

  logic               bus_cyc;
  logic [31:0]        bus_addr;
  logic               bus_done;
  logic [1:0]         exc_mis;
  logic [1:0]         exc_fault;

  assign bus_done = iport_ack_i || iport_err_i;
  assign valid_o  = (fifo_count != '0);
  assign fifo_pop = valid_o && ready_i;

  always_comb begin
    exc_mis                          = 2'b00;
    exc_mis[CAUSE_FETCH_MISALIGNED]  = 1'b1;
    exc_fault                        = 2'b00;
    exc_fault[CAUSE_FETCH_FAULT]     = 1'b1;
  end

  fetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (fifo_clear),
    .wr_data (fifo_din),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  // State, fetch PC and squashed-read address registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg        <= ST_IDLE;
      fetch_pc_reg     <= RESET_PC;
      discard_addr_reg <= RESET_PC;
    end else begin
      state_reg        <= state_next;
      fetch_pc_reg     <= fetch_pc_next;
      discard_addr_reg <= discard_addr_next;
    end
  end

  // Next-state, bus request and buffer push decisions; redirect overrides
  always_comb begin
    state_next        = state_reg;
    fetch_pc_next     = fetch_pc_reg;
    discard_addr_next = discard_addr_reg;
    fifo_push         = 1'b0;
    fifo_din          = make_entry(NOP_INSTR, fetch_pc_reg, 2'b00);
    fifo_clear        = redirect_i;
    bus_cyc           = 1'b0;
    bus_addr          = fetch_pc_reg;

    case (state_reg)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        bus_cyc = 1'b1;
        if (iport_err_i) begin
          fifo_push  = 1'b1;
          fifo_din   = make_entry(NOP_INSTR, fetch_pc_reg, exc_fault);
          state_next = ST_HALT;
        end else if (iport_ack_i) begin
          fifo_push     = 1'b1;
          fifo_din      = make_entry(iport_dat_i, fetch_pc_reg, 2'b00);
          fetch_pc_next = fetch_pc_reg + 32'd4;
          // Post-update occupancy is count + 1 - pop
          if (fifo_pop || (fifo_count < CW'(DEPTH - 1))) state_next = ST_REQ;
          else                                           state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_pop || (fifo_count < CW'(DEPTH))) state_next = ST_REQ;
      end
      ST_DISCARD: begin
        bus_cyc  = 1'b1;
        bus_addr = discard_addr_reg;
        if (bus_done) state_next = ST_REQ;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase

    if (redirect_i) begin
      fifo_push     = 1'b0;
      fetch_pc_next = redirect_pc_i;
      if (redirect_pc_i[1:0] != 2'b00) begin
        fifo_push  = 1'b1;
        fifo_din   = make_entry(NOP_INSTR, redirect_pc_i, exc_mis);
        state_next = ST_HALT;
      end else if (((state_reg == ST_REQ) || (state_reg == ST_DISCARD)) && !bus_done) begin
        state_next = ST_DISCARD;
        if (state_reg == ST_REQ) discard_addr_next = fetch_pc_reg;
      end else begin
        state_next = ST_REQ;
      end
    end
  end

  assign iport_cyc_o  = bus_cyc;
  assign iport_stb_o  = bus_cyc;
  assign iport_addr_o = {bus_addr[31:2], 2'b00};

  assign instruction_o        = valid_o ? fifo_head[ENTRY_W-1 -: 32] : NOP_INSTR;
  assign pc_o                 = valid_o ? fifo_head[33:2] : 32'h0000_0000;
  assign e_fetch_misaligned_o = valid_o && fifo_head[CAUSE_FETCH_MISALIGNED];
  assign e_fetch_fault_o      = valid_o && fifo_head[CAUSE_FETCH_FAULT];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a latency-programmable instruction memory
// responder, a scoreboard of expected decoder-side entries, and a scripted
// sequence covering streaming, backpressure, squash, exceptions and wrap.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] iport_addr_o;
  logic        iport_cyc_o;
  logic        iport_stb_o;
  logic [31:0] iport_dat_i;
  logic        iport_ack_i;
  logic        iport_err_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        e_fetch_misaligned_o;
  logic        e_fetch_fault_o;
  logic        valid_o;
  logic        ready_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  exc;   // {fault, misaligned}
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int vec_cnt = 0;
  int err_cnt = 0;

  int          lat_cycles = 1;
  int          wait_cnt;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        bus_hit;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .iport_addr_o         (iport_addr_o),
    .iport_cyc_o          (iport_cyc_o),
    .iport_stb_o          (iport_stb_o),
    .iport_dat_i          (iport_dat_i),
    .iport_ack_i          (iport_ack_i),
    .iport_err_i          (iport_err_i),
    .redirect_i           (redirect_i),
    .redirect_pc_i        (redirect_pc_i),
    .instruction_o        (instruction_o),
    .pc_o                 (pc_o),
    .e_fetch_misaligned_o (e_fetch_misaligned_o),
    .e_fetch_fault_o      (e_fetch_fault_o),
    .valid_o              (valid_o),
    .ready_i              (ready_i)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory responder: completes a strobe after lat_cycles cycles
  assign bus_hit     = iport_cyc_o && iport_stb_o && (wait_cnt == lat_cycles - 1);
  assign iport_ack_i = bus_hit && !(err_en && (iport_addr_o == err_addr));
  assign iport_err_i = bus_hit && err_en && (iport_addr_o == err_addr);
  assign iport_dat_i = mem_word(iport_addr_o);

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i)                        wait_cnt <= 0;
    else if (!iport_cyc_o || bus_hit)  wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_entry(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [1:0] exc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.exc   = exc;
    exp_q.push_back(e);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    #1;
    check("rst_async_cyc", 64'(iport_cyc_o), 64'd0);
    check("rst_async_valid", 64'(valid_o), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  // Scoreboard: every accepted head entry must match the oldest expectation
  always @(negedge clk) begin
    if (rst_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_instr", 64'(instruction_o), 64'(mon_e.instr));
        check("sb_pc", 64'(pc_o), 64'(mon_e.pc));
        check("sb_exc", 64'({e_fetch_fault_o, e_fetch_misaligned_o}), 64'(mon_e.exc));
        $display("accept pc=%08h instr=%08h exc=%b", pc_o, instruction_o,
                 {e_fetch_fault_o, e_fetch_misaligned_o});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst_cyc", 64'(iport_cyc_o), 64'd0);
    check("rst_stb", 64'(iport_stb_o), 64'd0);
    check("rst_addr", 64'(iport_addr_o), 64'h0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_instr", 64'(instruction_o), 64'(NOP));
    check("rst_pc", 64'(pc_o), 64'd0);
    check("rst_mis", 64'(e_fetch_misaligned_o), 64'd0);
    check("rst_fault", 64'(e_fetch_fault_o), 64'd0);

    // Release: one IDLE cycle, then streaming at one word per cycle
    rst_i = 1'b1;
    ready_i = 1'b1;
    mid();
    check("idle_cyc", 64'(iport_cyc_o), 64'd0);
    cyc_end();
    for (int k = 0; k < 8; k++) begin
      expect_entry(mem_word(32'(4 * k)), 32'(4 * k), 2'b00);
      mid();
      check("stream_addr", 64'(iport_addr_o), 64'(4 * k));
      check("stream_stb", 64'(iport_stb_o), 64'd1);
      if (k > 0) check("stream_valid", 64'(valid_o), 64'd1);
      cyc_end();
    end
    mid();
    check("stream_drain", 64'(exp_q.size()), 64'd0);
    cyc_end();

    // Reset mid-stream, then backpressure with ready low
    ready_i = 1'b0;
    do_reset();
    mid();
    check("bp_idle_cyc", 64'(iport_cyc_o), 64'd0);
    cyc_end();
    expect_entry(mem_word(32'h0), 32'h0, 2'b00);
    mid();
    check("bp_addr0", 64'(iport_addr_o), 64'h0);
    cyc_end();
    expect_entry(mem_word(32'h4), 32'h4, 2'b00);
    mid();
    check("bp_addr4", 64'(iport_addr_o), 64'h4);
    check("bp_lat_valid", 64'(valid_o), 64'd1);
    check("bp_lat_pc", 64'(pc_o), 64'h0);
    cyc_end();
    for (int k = 0; k < 2; k++) begin
      mid();
      check("bp_wait_cyc", 64'(iport_cyc_o), 64'd0);
      check("bp_wait_pc", 64'(pc_o), 64'h0);
      cyc_end();
    end
    ready_i = 1'b1;
    mid();
    check("bp_pop_cyc", 64'(iport_cyc_o), 64'd0);
    cyc_end();
    expect_entry(mem_word(32'h8), 32'h8, 2'b00);
    mid();
    check("bp_resume_cyc", 64'(iport_cyc_o), 64'd1);
    check("bp_resume_addr", 64'(iport_addr_o), 64'h8);
    cyc_end();
    ready_i = 1'b0;
    mid();
    check("bp_pending", 64'(exp_q.size()), 64'd1);
    cyc_end();

    // Squash: redirect while a 3-cycle read of 0x40 is outstanding
    lat_cycles = 3;
    ready_i = 1'b1;
    do_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    mid();
    cyc_end();
    redirect_i = 1'b0;
    mid();
    check("sq_addr40", 64'(iport_addr_o), 64'h40);
    cyc_end();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    mid();
    cyc_end();
    redirect_i = 1'b0;
    expect_entry(mem_word(32'h100), 32'h100, 2'b00);
    mid();
    check("sq_discard_cyc", 64'(iport_cyc_o), 64'd1);
    check("sq_discard_addr", 64'(iport_addr_o), 64'h40);
    check("sq_discard_valid", 64'(valid_o), 64'd0);
    cyc_end();
    for (int k = 0; k < 3; k++) begin
      mid();
      check("sq_new_addr", 64'(iport_addr_o), 64'h100);
      check("sq_no_valid", 64'(valid_o), 64'd0);
      cyc_end();
    end
    mid();
    check("sq_first_pc", 64'(pc_o), 64'h100);
    cyc_end();

    // Misaligned redirect: one exception entry, no bus access, halt
    redirect_i = 1'b1;
    redirect_pc_i = 32'h102;
    ready_i = 1'b0;
    mid();
    check("sq_drain", 64'(exp_q.size()), 64'd0);
    expect_entry(NOP, 32'h102, 2'b01);
    cyc_end();
    redirect_i = 1'b0;
    mid();
    check("mis_cyc", 64'(iport_cyc_o), 64'd0);
    check("mis_valid", 64'(valid_o), 64'd1);
    check("mis_pc", 64'(pc_o), 64'h102);
    check("mis_flag", 64'(e_fetch_misaligned_o), 64'd1);
    check("mis_instr", 64'(instruction_o), 64'(NOP));
    cyc_end();
    ready_i = 1'b1;
    mid();
    check("mis_halt_cyc", 64'(iport_cyc_o), 64'd0);
    cyc_end();
    mid();
    check("mis_halt_valid", 64'(valid_o), 64'd0);
    check("mis_halt_cyc2", 64'(iport_cyc_o), 64'd0);
    cyc_end();

    // Bus error at 0x20: fault entry, then no more strobes
    lat_cycles = 1;
    err_en = 1'b1;
    err_addr = 32'h20;
    ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h20;
    expect_entry(NOP, 32'h20, 2'b10);
    mid();
    cyc_end();
    redirect_i = 1'b0;
    mid();
    check("err_addr", 64'(iport_addr_o), 64'h20);
    check("err_cyc", 64'(iport_cyc_o), 64'd1);
    cyc_end();
    mid();
    check("err_halt_cyc", 64'(iport_cyc_o), 64'd0);
    check("err_pc", 64'(pc_o), 64'h20);
    check("err_fault", 64'(e_fetch_fault_o), 64'd1);
    check("err_mis", 64'(e_fetch_misaligned_o), 64'd0);
    check("err_instr", 64'(instruction_o), 64'(NOP));
    cyc_end();
    ready_i = 1'b1;
    mid();
    check("err_halt_cyc2", 64'(iport_cyc_o), 64'd0);
    cyc_end();
    ready_i = 1'b0;
    err_en = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0;
    mid();
    check("err_empty", 64'(valid_o), 64'd0);
    cyc_end();
    redirect_i = 1'b0;
    mid();
    check("restart_cyc", 64'(iport_cyc_o), 64'd1);
    check("restart_addr", 64'(iport_addr_o), 64'h0);
    cyc_end();

    // Redirect in the same cycle as an ack: response dropped
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    mid();
    check("sim_ack_addr", 64'(iport_addr_o), 64'h4);
    exp_q.delete();
    cyc_end();
    redirect_i = 1'b0;
    expect_entry(mem_word(32'h200), 32'h200, 2'b00);
    mid();
    check("sim_ack_empty", 64'(valid_o), 64'd0);
    check("sim_ack_newaddr", 64'(iport_addr_o), 64'h200);
    cyc_end();
    expect_entry(mem_word(32'h204), 32'h204, 2'b00);
    mid();
    check("sim_fill_pc", 64'(pc_o), 64'h200);
    cyc_end();

    // Redirect in the same cycle as a pop from a full buffer
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    ready_i = 1'b1;
    mid();
    check("sim_full_cyc", 64'(iport_cyc_o), 64'd0);
    check("sim_pop_left", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    cyc_end();
    redirect_i = 1'b0;
    ready_i = 1'b0;
    expect_entry(mem_word(32'h300), 32'h300, 2'b00);
    mid();
    check("sim_pop_empty", 64'(valid_o), 64'd0);
    check("sim_pop_addr", 64'(iport_addr_o), 64'h300);
    cyc_end();
    expect_entry(mem_word(32'h304), 32'h304, 2'b00);
    mid();
    check("sim_pop_pc", 64'(pc_o), 64'h300);
    cyc_end();
    ready_i = 1'b1;
    mid();
    cyc_end();
    mid();
    check("sim_resume_addr", 64'(iport_addr_o), 64'h308);
    cyc_end();

    // Wrap of the fetch PC through 0xFFFF_FFFC
    ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    mid();
    check("sim_no_dup", 64'(exp_q.size()), 64'd0);
    check("sim_next_pc", 64'(pc_o), 64'h308);
    cyc_end();
    redirect_i = 1'b0;
    ready_i = 1'b1;
    expect_entry(mem_word(32'hFFFF_FFF8), 32'hFFFF_FFF8, 2'b00);
    mid();
    check("wrap_addr_f8", 64'(iport_addr_o), 64'hFFFF_FFF8);
    cyc_end();
    expect_entry(mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 2'b00);
    mid();
    check("wrap_addr_fc", 64'(iport_addr_o), 64'hFFFF_FFFC);
    cyc_end();
    expect_entry(mem_word(32'h0), 32'h0, 2'b00);
    mid();
    check("wrap_addr_0", 64'(iport_addr_o), 64'h0);
    cyc_end();
    mid();
    cyc_end();
    ready_i = 1'b0;
    mid();
    check("wrap_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
